// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit data / 16-bit address memory bus.
// Masters hold a level req for a whole burst. After a grant drops, the bus
// spends one TURN cycle and one IDLE cycle before the next grant.
// All bus outputs are registered copies of the current owner's signals.
// Optional feature (macro MEM_BUS_ARB_TIMEOUT_EN): an owner is preempted after
// HOLD_LIMIT owned cycles when another master is waiting.
module mem_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned HOLD_LIMIT  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        req,
    output logic [NUM_MASTERS-1:0]        gnt,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]        m_r,
    input  logic [NUM_MASTERS-1:0]        m_w,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]             bus_wdata,
    input  logic [DATA_W-1:0]             bus_rdata,
    output logic                          bus_r,
    output logic                          bus_w,
    output logic                          bus_oe,
    output logic                          err
);

    localparam int unsigned PTR_W = $clog2(NUM_MASTERS);
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam logic [NUM_MASTERS-1:0] GntOne = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || HOLD_LIMIT < 1) begin : g_bad_cfg
        $error("mem_bus_arbiter: unsupported parameter values");
    end

    typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

    state_e                 state_q;
    logic [PTR_W-1:0]       owner_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       owner_next;
    logic [PTR_W-1:0]       pick;
    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] req_eff;
    logic [ADDR_W-1:0]      own_addr;
    logic [DATA_W-1:0]      own_wdata;
    logic                   own_r;
    logic                   own_w;
    logic                   own_req;
    logic                   preempt;
    logic                   release_bus;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(HOLD_LIMIT + 1);
    logic [CNT_W-1:0]       hold_cnt_q;
    logic [NUM_MASTERS-1:0] blocked_q;  // preempted masters, cleared once their req is seen low

    // Preempt once the owner has used its budget and someone else is eligible
    always_comb begin
        req_eff = req & ~blocked_q;
        preempt = (int'(hold_cnt_q) + 1 >= int'(HOLD_LIMIT)) && (|(req_eff & ~gnt));
    end
`else
    assign req_eff = req;
    assign preempt = 1'b0;
`endif

    // Read data is a plain pass-through; only the granted master samples it
    assign m_rdata = bus_rdata;

    assign owner_next  = (owner_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    assign release_bus = !own_req || preempt;

    // Select the current owner's request and bus signals
    always_comb begin
        own_addr  = '0;
        own_wdata = '0;
        own_r     = 1'b0;
        own_w     = 1'b0;
        own_req   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (owner_q == PTR_W'(k)) begin
                own_addr  = m_addr[k*ADDR_W +: ADDR_W];
                own_wdata = m_wdata[k*DATA_W +: DATA_W];
                own_r     = m_r[k];
                own_w     = m_w[k];
                own_req   = req[k];
            end
        end
    end

    // First eligible requester at or after rr_ptr, wrapping
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [PTR_W-1:0] idx;
        pick_valid = 1'b0;
        pick       = '0;
        sum        = '0;
        idx        = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            sum = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_MASTERS)) begin
                sum = sum - SUM_W'(NUM_MASTERS);
            end
            idx = sum[PTR_W-1:0];
            if (!pick_valid && req_eff[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    // Arbitration FSM with registered grant and bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            gnt        <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_r      <= 1'b0;
            bus_w      <= 1'b0;
            bus_oe     <= 1'b0;
            err        <= 1'b0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            blocked_q  <= '0;
`endif
        end else begin
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            blocked_q <= blocked_q & req;
`endif
            unique case (state_q)
                StIdle: begin
                    bus_r  <= 1'b0;
                    bus_w  <= 1'b0;
                    bus_oe <= 1'b0;
                    if (pick_valid) begin
                        gnt     <= GntOne << pick;
                        owner_q <= pick;
                        state_q <= StOwn;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                        hold_cnt_q <= '0;
`endif
                    end
                end
                StOwn: begin
                    if (own_r && own_w) begin
                        err <= 1'b1;
                    end
                    if (release_bus) begin
                        gnt      <= '0;
                        rr_ptr_q <= owner_next;
                        bus_r    <= 1'b0;
                        bus_w    <= 1'b0;
                        bus_oe   <= 1'b0;
                        state_q  <= StTurn;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                        if (preempt) begin
                            blocked_q <= (blocked_q & req) | gnt;
                        end
`endif
                    end else begin
                        bus_addr  <= own_addr;
                        bus_wdata <= own_wdata;
                        // Conflicting strobes are suppressed on the bus
                        bus_r     <= own_r & ~own_w;
                        bus_w     <= own_w & ~own_r;
                        bus_oe    <= own_w;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                        if (int'(hold_cnt_q) + 1 < int'(HOLD_LIMIT)) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                StTurn: begin
                    bus_r   <= 1'b0;
                    bus_w   <= 1'b0;
                    bus_oe  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (4 masters, HOLD_LIMIT=8).
module tb_mem_bus_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic             clk;
    logic             reset;
    logic [NM-1:0]    req;
    logic [NM-1:0]    gnt;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_r;
    logic [NM-1:0]    m_w;
    logic [DW-1:0]    m_rdata;
    logic [AW-1:0]    bus_addr;
    logic [DW-1:0]    bus_wdata;
    logic [DW-1:0]    bus_rdata;
    logic             bus_r;
    logic             bus_w;
    logic             bus_oe;
    logic             err;

    int unsigned checks;
    int unsigned errors;

    mem_bus_arbiter #(
        .NUM_MASTERS(NM),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .HOLD_LIMIT (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_r      (m_r),
        .m_w      (m_w),
        .m_rdata  (m_rdata),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_r    (bus_r),
        .bus_w    (bus_w),
        .bus_oe   (bus_oe),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int          k;
        int unsigned held;
        logic [3:0]  exp_g;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        req       = '0;
        m_addr    = '0;
        m_wdata   = '0;
        m_r       = '0;
        m_w       = '0;
        bus_rdata = '0;

        // Asynchronous reset values, before any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_bus_r", 32'(bus_r), 32'h0);
        check("rst_bus_w", 32'(bus_w), 32'h0);
        check("rst_bus_oe", 32'(bus_oe), 32'h0);
        check("rst_bus_addr", 32'(bus_addr), 32'h0);
        check("rst_bus_wdata", 32'(bus_wdata), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        step();
        step();
        reset = 1'b0;

        // Single read by master 0
        req[0] = 1'b1;
        step();
        check("t1_gnt", 32'(gnt), 32'h1);
        m_addr[0 +: AW] = 16'h2000;
        m_r[0] = 1'b1;
        step();
        check("t1_bus_addr", 32'(bus_addr), 32'h2000);
        check("t1_bus_r", 32'(bus_r), 32'h1);
        check("t1_bus_w", 32'(bus_w), 32'h0);
        bus_rdata = 8'hA5;
        #1;
        check("t1_m_rdata", 32'(m_rdata), 32'hA5);
        req[0] = 1'b0;
        m_r[0] = 1'b0;
        step();
        check("t1_rel_gnt", 32'(gnt), 32'h0);
        check("t1_rel_bus_r", 32'(bus_r), 32'h0);
        check("t1_hold_addr", 32'(bus_addr), 32'h2000);
        do_reset();

        // All masters requesting: rotation 0,1,2,3,0 with a 2-cycle gap
        m_addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        m_r    = 4'hF;
        req    = 4'hF;
        for (int n = 0; n < 5; n++) begin
            k = n % 4;
            exp_g = 4'b0001 << k;
            step();
            check("rr_gnt", 32'(gnt), 32'(exp_g));
            step();
            check("rr_gnt_hold", 32'(gnt), 32'(exp_g));
            step();
            check("rr_gnt_hold2", 32'(gnt), 32'(exp_g));
            check("rr_bus_r", 32'(bus_r), 32'h1);
            check("rr_bus_addr", 32'(bus_addr), 32'h1111 * (k + 1));
            req[k] = 1'b0;
            step();
            check("rr_turn_gnt", 32'(gnt), 32'h0);
            check("rr_turn_r", 32'(bus_r), 32'h0);
            check("rr_turn_w", 32'(bus_w), 32'h0);
            check("rr_turn_addr", 32'(bus_addr), 32'h1111 * (k + 1));
            req[k] = 1'b1;
            step();
            check("rr_idle_gnt", 32'(gnt), 32'h0);
            check("rr_idle_r", 32'(bus_r), 32'h0);
        end
        req = '0;
        m_r = '0;
        do_reset();

        // Owner 2 writes while non-owner 1 also strobes m_w
        req = 4'b0100;
        step();
        check("t3_gnt", 32'(gnt), 32'h4);
        m_addr[2*AW +: AW]  = 16'h1F00;
        m_wdata[2*DW +: DW] = 8'h3C;
        m_addr[1*AW +: AW]  = 16'hBEEF;
        m_wdata[1*DW +: DW] = 8'h77;
        m_w = 4'b0110;
        step();
        check("t3_bus_w", 32'(bus_w), 32'h1);
        check("t3_bus_oe", 32'(bus_oe), 32'h1);
        check("t3_bus_wdata", 32'(bus_wdata), 32'h3C);
        check("t3_bus_addr", 32'(bus_addr), 32'h1F00);
        check("t3_bus_r", 32'(bus_r), 32'h0);
        m_w = 4'b0010;
        step();
        check("t3_nonowner_w", 32'(bus_w), 32'h0);
        check("t3_nonowner_oe", 32'(bus_oe), 32'h0);
        check("t3_nonowner_addr", 32'(bus_addr), 32'h1F00);

        // Owner 2 raises both strobes for one cycle
        m_r = 4'b0100;
        m_w = 4'b0100;
        step();
        check("t4_bus_r", 32'(bus_r), 32'h0);
        check("t4_bus_w", 32'(bus_w), 32'h0);
        check("t4_err", 32'(err), 32'h1);
        m_r = '0;
        m_w = '0;
        step();
        check("t4_err_sticky", 32'(err), 32'h1);
        req = '0;
        step();
        step();
        check("t4_err_sticky2", 32'(err), 32'h1);
        do_reset();
        check("t4_err_cleared", 32'(err), 32'h0);

        // Reset mid-write by master 1 acts without a clock edge
        req = 4'b0010;
        m_w = 4'b0010;
        step();
        check("t5_gnt", 32'(gnt), 32'h2);
        step();
        check("t5_bus_w", 32'(bus_w), 32'h1);
        check("t5_bus_oe", 32'(bus_oe), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'h0);
        check("t5_async_w", 32'(bus_w), 32'h0);
        check("t5_async_oe", 32'(bus_oe), 32'h0);
        req = '0;
        m_w = '0;
        step();
        step();
        reset = 1'b0;

        // Request dropped right after arbitration: 1-cycle grant, no error
        req = 4'b1000;
        step();
        check("t6_gnt", 32'(gnt), 32'h8);
        req = '0;
        step();
        check("t6_gnt_drop", 32'(gnt), 32'h0);
        check("t6_err", 32'(err), 32'h0);
        step();
        step();

        // Master 0 holds the bus while master 3 waits
        req = 4'b1001;
        step();
        check("t7_gnt", 32'(gnt), 32'h1);
        held = 1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (gnt == 4'b0001) held++;
            else break;
        end
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        check("t7_held_cycles", held, 32'd8);
        check("t7_preempt_gnt", 32'(gnt), 32'h0);
        step();
        check("t7_gap_gnt", 32'(gnt), 32'h0);
        step();
        check("t7_gnt3", 32'(gnt), 32'h8);
        req = 4'b0001;
        step();
        step();
        step();
        check("t7_blocked", 32'(gnt), 32'h0);
        req = '0;
        step();
        req = 4'b0001;
        step();
        check("t7_regrant", 32'(gnt), 32'h1);
`else
        check("t7_held_cycles", held, 32'd121);
        check("t7_still_gnt", 32'(gnt), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit data / 16-bit address memory bus between up to NUM_MASTERS requesters: the CPU core, plus DMA and video fetch units.
- Round-robin grant with an explicit request/grant handshake.
- One turnaround (dead) cycle between owners, so two masters never drive the bus in adjacent cycles.
- Sits between the masters and the top-level memory/tristate glue.
- All bus outputs are unidirectional; tristating is done at top level.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- HOLD_LIMIT, 64, max consecutive owned cycles; used only with MEM_BUS_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_MASTERS  per-master bus request; level, held for the whole transaction burst.
- gnt  out  NUM_MASTERS  per-master grant; one-hot or zero.
- m_addr  in  NUM_MASTERS*ADDR_W  master addresses; master k occupies bits [k*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_MASTERS*DATA_W  master write data, packed the same way.
- m_r  in  NUM_MASTERS  master read strobes.
- m_w  in  NUM_MASTERS  master write strobes.
- m_rdata  out  DATA_W  read data broadcast to all masters; only the granted master may sample it.
- bus_addr  out  ADDR_W  shared address.
- bus_wdata  out  DATA_W  shared write data.
- bus_rdata  in  DATA_W  data returned from memory.
- bus_r  out  1  shared read strobe.
- bus_w  out  1  shared write strobe.
- bus_oe  out  1  high when bus_wdata must be driven onto the tristate data bus.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; gnt=0; bus_r=bus_w=bus_oe=0; bus_addr=0; bus_wdata=0; err=0.
  - rr_ptr=0, so master 0 has highest priority first.
  - Reset mid-transaction drops gnt immediately; no write completes after reset asserts.
- States: IDLE, OWN, TURN.
- IDLE:
  - If any req is high, pick the first requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - Register gnt[k]=1 and owner=k, then go to OWN.
  - Latency from req rising to gnt high is 1 clock.
  - If no req is high, stay in IDLE with outputs at their reset values.
- OWN:
  - Bus outputs are registered copies of the owner's m_addr, m_wdata, m_r and m_w, so they lag the master by 1 clock.
  - bus_oe = registered m_w of the owner.
  - m_rdata = bus_rdata, combinational pass-through.
  - Non-owners' strobes are ignored.
  - If the owner has m_r and m_w high in the same cycle: bus_r=bus_w=0 for that cycle and err is set (sticky until reset).
  - When the owner drops req: gnt=0 on the next edge; rr_ptr=owner+1 (wraps); go to TURN.
- TURN:
  - Exactly one cycle with bus_r=bus_w=bus_oe=0.
  - bus_addr holds its last value.
  - Then go to IDLE; arbitration happens the next cycle.
  - Back-to-back different owners are therefore separated by 2 cycles (TURN + IDLE).
- Requests that appear or vanish while a master is not granted have no effect; there is no queueing beyond the level req.
- A master that raises req and then drops it before gnt arrives: if it is granted anyway, it receives a 1-cycle gnt and the arbiter goes OWN→TURN. This is legal and does not set err.
- Simultaneous requests from all masters: strict rotation 0,1,2,3,0… as each releases.

Optional Feature:
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to OWN and increments each OWN cycle.
  - When the counter reaches HOLD_LIMIT and any other req is high, the arbiter forcibly drops gnt and goes to TURN, with rr_ptr=owner+1.
  - The preempted master must drop and re-raise req; its req is ignored until it has been seen low for 1 cycle.
  - With no competing req, the counter saturates and no preemption occurs.
- Undefined: no counter; the owner holds the bus indefinitely.

Test Plan:
- Reset, then req[0]=1 → gnt=4'b0001 one clock later. m_addr0=16'h2000 with m_r0=1 → bus_addr=16'h2000, bus_r=1 one clock later; bus_rdata=8'hA5 → m_rdata=8'hA5.
- req=4'b1111 held constant, each owner releases after 3 cycles → grant order 0,1,2,3,0; exactly 2 cycles with gnt=0 between grants, with bus_r=bus_w=0 in TURN.
- Owner 2 writes m_addr=16'h1F00, m_wdata=8'h3C, m_w=1 → bus_w=1, bus_oe=1, bus_wdata=8'h3C next clock. Non-owner 1 asserting m_w=1 at the same time → no bus effect.
- Owner asserts m_r=m_w=1 for one cycle → bus_r=bus_w=0 that cycle; err=1 and stays 1 until reset.
- Assert reset while master 1 owns the bus with m_w=1 → gnt=0, bus_w=0, bus_oe=0 immediately (same cycle, no clock edge needed).
- With MEM_BUS_ARB_TIMEOUT_EN and HOLD_LIMIT=8: master 0 holds req and master 3 requests → gnt0 drops after 8 OWN cycles; gnt3 asserts 2 cycles later. With the macro undefined, master 0 keeps gnt for 100+ cycles.
